card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 The block SHALL have these ports: Clock, input, 1, system clock, rising-edge.
REQ-002 The block SHALL have these ports: resetn, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: deal, input, 1, request one card; level, sampled in IDLE only.
REQ-004 The block SHALL have these ports: newDeck, input, 1, rewind deck pointer to 0; synchronous, one-cycle pulse.
REQ-005 The block SHALL have these ports: shuffleOn, input, 1, shuffler owns deck RAM; dealing inhibited while high.
REQ-006 The block SHALL have these ports: DataOut, input, 6, deck RAM read data, card code 0..51.
REQ-007 The block SHALL have these ports: Address, output, 6, deck RAM read address; 6'b111111 when not reading.
REQ-008 The block SHALL have these ports: busy, output, 1, read in progress (any state except IDLE).
REQ-009 The block SHALL have these ports: cardValid, output, 1, one-cycle pulse when card outputs update.
REQ-010 The block SHALL have these ports: card, output, 6, last dealt raw code.
REQ-011 The block SHALL have these ports: rank, output, 4, 1=Ace .. 13=King.
REQ-012 The block SHALL have these ports: suit, output, 2, 0..3.
REQ-013 The block SHALL have these ports: points, output, 4, blackjack value: Ace=1, 2..10 face value, J/Q/K=10.
REQ-014 The block SHALL have these ports: cardsLeft, output, 6, 52 minus deck pointer.
REQ-015 The block SHALL have these ports: deckEmpty, output, 1, high when cardsLeft==0.
REQ-016 The block SHALL have these ports: badCard, output, 1, sticky; set when a fetched code is greater than 51.
REQ-017 The block SHALL have these ports: cutReached, output, 1, cut-card indicator (see Configuration).

Function
REQ-018 The block SHALL implement the FSM IDLE -> ADDR -> WAIT -> LATCH -> IDLE.
REQ-019 The block SHALL move IDLE -> ADDR on an edge where deal=1, shuffleOn=0 and deckEmpty=0; otherwise it SHALL remain in IDLE.
REQ-020 The block SHALL drive Address=ptr in the ADDR and WAIT states, and 6'b111111 in IDLE and LATCH.
REQ-021 The block SHALL capture DataOut in LATCH; this accommodates a synchronous RAM with registered address, giving 2 cycles of read latency.
REQ-022 On LATCH, the block SHALL update card/rank/suit/points, pulse cardValid=1 for one cycle and increment ptr by 1.
REQ-023 Latency SHALL be fixed: deal sampled at edge N, cardValid high after edge N+3; maximum throughput is one card per 4 cycles.
REQ-024 Decode: suit = card/13, rank = (card mod 13)+1, points = min(rank,10); all combinational from registered card, with no divider (compare/subtract chain).
REQ-025 If code >51: badCard=1, card=code, rank=0, suit=0, points=0, ptr still increments.
REQ-026 Once asserted, badCard SHALL stay high until reset or newDeck.
REQ-027 Held deal SHALL produce back-to-back deals every 4 cycles until deckEmpty or shuffleOn.
REQ-028 ptr SHALL saturate at 52; there is no wrap-around, and deal at deckEmpty is ignored (no cardValid).
REQ-029 newDeck in IDLE: ptr=0 and badCard=0 next edge.
REQ-030 newDeck in ADDR/WAIT/LATCH: the in-flight read SHALL complete (cardValid still pulses), then ptr=0 at the edge leaving LATCH, with newDeck winning over the increment.
REQ-031 shuffleOn rising during ADDR/WAIT: the block SHALL abort to IDLE next edge, with no cardValid and ptr unchanged; shuffleOn in LATCH SHALL be ignored.
REQ-032 The block SHALL never write the RAM; the top level muxes Address between shuffler and dealer on shuffleOn.

Reset
REQ-033 On resetn low, the block SHALL immediately set: state=IDLE, ptr=0, Address=6'b111111, busy=0, cardValid=0, card=0, badCard=0, cutReached=0.
REQ-034 Rank, suit and points SHALL decode to the reset card (rank=1, suit=0, points=1); cardsLeft=52, deckEmpty=0.
REQ-035 Reset mid-read SHALL discard the read with no cardValid.

Configuration
REQ-036 Macro CARD_DEALER_CUTCARD_EN: when defined, cutReached SHALL go high on the edge where cardsLeft becomes <13, and stay high until reset or newDeck; dealing continues normally.
REQ-037 When CARD_DEALER_CUTCARD_EN is undefined, cutReached SHALL be tied 0 and no comparator is built.

Verification
REQ-038 Reset, RAM preloaded addr i = i, deal=1 for one cycle -> Address=0 at ADDR/WAIT, cardValid after 3 edges, card=0, rank=1, suit=0, points=1, cardsLeft=51.
REQ-039 RAM addr 0 = 50, deal -> rank=12, suit=3, points=10; with RAM addr 0 = 9 -> rank=10, suit=0, points=10.
REQ-040 Deal held 52x4 cycles -> 52 cardValid pulses, deckEmpty=1, further deal gives no pulse, ptr stays 52; with CARD_DEALER_CUTCARD_EN defined, cutReached rises after the 40th card.
REQ-041 shuffleOn asserted in WAIT -> IDLE next edge, no cardValid, cardsLeft unchanged; next deal re-reads same address.
REQ-042 RAM addr 3 = 63 -> badCard=1 and stays high; newDeck -> badCard=0, cardsLeft=52.
REQ-043 newDeck pulsed in WAIT -> cardValid still pulses, then cardsLeft=52; resetn low in ADDR -> Address=6'b111111 immediately, no cardValid.

Source files
------------

// File: rtl/card_dealer.sv
// Deals one card per request from an external synchronous deck RAM (2-cycle read latency)
// and decodes it into rank/suit/blackjack points. Optional cut card: define CARD_DEALER_CUTCARD_EN.
module card_dealer (
  input  logic       Clock,
  input  logic       resetn,
  input  logic       deal,
  input  logic       newDeck,
  input  logic       shuffleOn,
  input  logic [5:0] DataOut,
  output logic [5:0] Address,
  output logic       busy,
  output logic       cardValid,
  output logic [5:0] card,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [3:0] points,
  output logic [5:0] cardsLeft,
  output logic       deckEmpty,
  output logic       badCard,
  output logic       cutReached,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, LATCH = 2'd3} state_t;

  state_t     state;
  logic [5:0] ptr;
  logic       new_pend;
  logic [5:0] ptr_inc;
  logic       rewind;
  logic       abort;
  logic       ptr_clear;
  logic       ptr_step;
  logic [5:0] rem;

  assign dbg_state = state;
  assign cardsLeft = 6'd52 - ptr;
  assign deckEmpty = (ptr == 6'd52);
  assign ptr_inc   = (ptr >= 6'd52) ? 6'd52 : ptr + 6'd1;

  // A newDeck seen mid-read is held until the read retires, then wins over the increment.
  assign rewind    = newDeck | new_pend;
  assign abort     = ((state == ADDR) || (state == WAIT)) && shuffleOn;
  assign ptr_clear = ((state == IDLE) && newDeck) || (((state == LATCH) || abort) && rewind);
  assign ptr_step  = (state == LATCH) && !rewind;

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= 6'd0;
      new_pend  <= 1'b0;
      Address   <= 6'h3f;
      busy      <= 1'b0;
      cardValid <= 1'b0;
      card      <= 6'd0;
      badCard   <= 1'b0;
    end else begin
      cardValid <= 1'b0;
      if (ptr_clear) begin
        ptr     <= 6'd0;
        badCard <= 1'b0;
      end else if (ptr_step) begin
        ptr <= ptr_inc;
        if (DataOut > 6'd51) badCard <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (deal && !shuffleOn && !deckEmpty) begin
            state   <= ADDR;
            busy    <= 1'b1;
            Address <= newDeck ? 6'd0 : ptr;
          end
        end
        ADDR, WAIT: begin
          if (shuffleOn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            Address  <= 6'h3f;
            new_pend <= 1'b0;
          end else begin
            if (newDeck) new_pend <= 1'b1;
            if (state == ADDR) begin
              state <= WAIT;
            end else begin
              state   <= LATCH;
              Address <= 6'h3f;
            end
          end
        end
        LATCH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cardValid <= 1'b1;
          card      <= DataOut;
          new_pend  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divider-free decode: peel off whole suits of 13, remainder gives the rank.
  always_comb begin
    rem    = card;
    suit   = 2'd0;
    rank   = 4'd0;
    points = 4'd0;
    if (card <= 6'd51) begin
      if (card >= 6'd39) begin
        suit = 2'd3;
        rem  = card - 6'd39;
      end else if (card >= 6'd26) begin
        suit = 2'd2;
        rem  = card - 6'd26;
      end else if (card >= 6'd13) begin
        suit = 2'd1;
        rem  = card - 6'd13;
      end
      rank   = rem[3:0] + 4'd1;
      points = (rank > 4'd10) ? 4'd10 : rank;
    end
  end

`ifdef CARD_DEALER_CUTCARD_EN
  // Fewer than 13 cards left means ptr has reached 40.
  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      cutReached <= 1'b0;
    end else if (ptr_clear) begin
      cutReached <= 1'b0;
    end else if (ptr_step && (ptr_inc >= 6'd40)) begin
      cutReached <= 1'b1;
    end
  end
`else
  assign cutReached = 1'b0;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: decode table plus hand-written multi-cycle sequences
// (full deck, shuffle abort, bad card, newDeck mid-read, reset mid-read).
module tb_card_dealer;

  logic       Clock = 1'b0;
  logic       resetn = 1'b0;
  logic       deal = 1'b0;
  logic       newDeck = 1'b0;
  logic       shuffleOn = 1'b0;
  logic [5:0] DataOut;
  logic [5:0] Address;
  logic       busy, cardValid, deckEmpty, badCard, cutReached;
  logic [5:0] card, cardsLeft;
  logic [3:0] rank, points;
  logic [1:0] suit, dbg_state;

  int n_vec = 0;
  int n_err = 0;

`ifdef CARD_DEALER_CUTCARD_EN
  localparam int CUT_EN = 1;
`else
  localparam int CUT_EN = 0;
`endif

  card_dealer dut (
    .Clock(Clock), .resetn(resetn), .deal(deal), .newDeck(newDeck), .shuffleOn(shuffleOn),
    .DataOut(DataOut), .Address(Address), .busy(busy), .cardValid(cardValid), .card(card),
    .rank(rank), .suit(suit), .points(points), .cardsLeft(cardsLeft), .deckEmpty(deckEmpty),
    .badCard(badCard), .cutReached(cutReached), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 Clock = ~Clock;

  // deck RAM model: registered address, registered data
  logic [5:0] mem [0:63];
  logic [5:0] addr_q, data_q;
  always @(posedge Clock) begin
    addr_q <= Address;
    data_q <= mem[addr_q];
  end
  assign DataOut = data_q;

  typedef struct {
    logic [5:0] code;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [3:0] pts;
    logic       bad;
  } vec_t;
  vec_t vt [15];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    deal = 1'b0;
    newDeck = 1'b0;
    shuffleOn = 1'b0;
    @(posedge Clock);
    #1;
    resetn = 1'b1;
    tick();
  endtask

  task automatic load_deck();
    for (int i = 0; i < 64; i++) mem[i] = 6'(i);
  endtask

  // driver: request one card, wait (bounded) for the cardValid cycle
  task automatic deal_one(output bit got);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (cardValid) got = 1'b1;
    end
  endtask

  task automatic expect_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (cardValid) seen = 1'b1;
    end
    check(name, 32'(seen), 0);
  endtask

  initial begin
    bit got;
    int pulses, last_cyc;

    vt[0]  = '{6'd0,  4'd1,  2'd0, 4'd1,  1'b0};
    vt[1]  = '{6'd9,  4'd10, 2'd0, 4'd10, 1'b0};
    vt[2]  = '{6'd12, 4'd13, 2'd0, 4'd10, 1'b0};
    vt[3]  = '{6'd13, 4'd1,  2'd1, 4'd1,  1'b0};
    vt[4]  = '{6'd25, 4'd13, 2'd1, 4'd10, 1'b0};
    vt[5]  = '{6'd26, 4'd1,  2'd2, 4'd1,  1'b0};
    vt[6]  = '{6'd38, 4'd13, 2'd2, 4'd10, 1'b0};
    vt[7]  = '{6'd39, 4'd1,  2'd3, 4'd1,  1'b0};
    vt[8]  = '{6'd50, 4'd12, 2'd3, 4'd10, 1'b0};
    vt[9]  = '{6'd51, 4'd13, 2'd3, 4'd10, 1'b0};
    vt[10] = '{6'd4,  4'd5,  2'd0, 4'd5,  1'b0};
    vt[11] = '{6'd22, 4'd10, 2'd1, 4'd10, 1'b0};
    vt[12] = '{6'd30, 4'd5,  2'd2, 4'd5,  1'b0};
    vt[13] = '{6'd52, 4'd0,  2'd0, 4'd0,  1'b1};
    vt[14] = '{6'd63, 4'd0,  2'd0, 4'd0,  1'b1};

    load_deck();
    do_reset();

    // reset state
    check("rst_address", 32'(Address), 63);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(cardValid), 0);
    check("rst_card", 32'(card), 0);
    check("rst_rank", 32'(rank), 1);
    check("rst_suit", 32'(suit), 0);
    check("rst_points", 32'(points), 1);
    check("rst_left", 32'(cardsLeft), 52);
    check("rst_empty", 32'(deckEmpty), 0);
    check("rst_bad", 32'(badCard), 0);
    check("rst_cut", 32'(cutReached), 0);

    // first deal, cycle by cycle
    deal = 1'b1;
    tick();
    deal = 1'b0;
    check("addr_state_addr", 32'(Address), 0);
    check("addr_busy", 32'(busy), 1);
    tick();
    check("wait_addr", 32'(Address), 0);
    check("wait_valid", 32'(cardValid), 0);
    tick();
    check("latch_addr", 32'(Address), 63);
    check("latch_valid", 32'(cardValid), 0);
    tick();
    check("lat3_valid", 32'(cardValid), 1);
    check("lat3_card", 32'(card), 0);
    check("lat3_rank", 32'(rank), 1);
    check("lat3_points", 32'(points), 1);
    check("lat3_left", 32'(cardsLeft), 51);
    check("lat3_busy", 32'(busy), 0);
    tick();
    check("valid_one_cycle", 32'(cardValid), 0);

    // decode table
    for (int v = 0; v < 15; v++) begin
      do_reset();
      mem[0] = vt[v].code;
      deal_one(got);
      check("tbl_valid", 32'(got), 1);
      check("tbl_card", 32'(card), 32'(vt[v].code));
      check("tbl_rank", 32'(rank), 32'(vt[v].rank));
      check("tbl_suit", 32'(suit), 32'(vt[v].suit));
      check("tbl_points", 32'(points), 32'(vt[v].pts));
      check("tbl_bad", 32'(badCard), 32'(vt[v].bad));
      check("tbl_left", 32'(cardsLeft), 51);
    end
    load_deck();

    // full deck with deal held
    do_reset();
    deal = 1'b1;
    pulses = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 52 * 4 + 30; cyc++) begin
      tick();
      if (cardValid) begin
        pulses++;
        check("deck_card", 32'(card), pulses - 1);
        if (last_cyc >= 0) check("deck_spacing", cyc - last_cyc, 4);
        else check("deck_first_lat", cyc, 3);
        last_cyc = cyc;
        if (pulses == 39) check("cut_before", 32'(cutReached), 0);
        if (pulses == 40) check("cut_after", 32'(cutReached), CUT_EN);
      end
    end
    deal = 1'b0;
    check("deck_pulses", pulses, 52);
    check("deck_empty", 32'(deckEmpty), 1);
    check("deck_left", 32'(cardsLeft), 0);
    check("deck_busy", 32'(busy), 0);
    check("deck_cut_hold", 32'(cutReached), CUT_EN);

    // shuffle abort in WAIT
    do_reset();
    deal_one(got);
    tick();
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    check("abort_in_wait", 32'(dbg_state), 2);
    shuffleOn = 1'b1;
    tick();
    check("abort_state", 32'(dbg_state), 0);
    check("abort_addr", 32'(Address), 63);
    check("abort_busy", 32'(busy), 0);
    shuffleOn = 1'b0;
    expect_no_valid("abort_no_valid", 5);
    check("abort_left", 32'(cardsLeft), 51);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    check("reread_addr", 32'(Address), 1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      if (cardValid) got = 1'b1;
    end
    check("reread_valid", 32'(got), 1);
    check("reread_card", 32'(card), 1);

    // bad card is sticky until newDeck
    do_reset();
    mem[3] = 6'd63;
    for (int i = 0; i < 4; i++) deal_one(got);
    check("bad_valid", 32'(got), 1);
    check("bad_card", 32'(card), 63);
    check("bad_flag", 32'(badCard), 1);
    check("bad_rank", 32'(rank), 0);
    check("bad_left", 32'(cardsLeft), 48);
    deal_one(got);
    check("bad_next_card", 32'(card), 4);
    check("bad_sticky", 32'(badCard), 1);
    newDeck = 1'b1;
    tick();
    newDeck = 1'b0;
    check("newdeck_bad", 32'(badCard), 0);
    check("newdeck_left", 32'(cardsLeft), 52);
    mem[3] = 6'd3;

    // newDeck during WAIT
    do_reset();
    deal_one(got);
    tick();
    deal = 1'b1;
    tick();
    deal = 1'b0;
    tick();
    newDeck = 1'b1;
    tick();
    newDeck = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (cardValid) got = 1'b1;
      else tick();
    end
    check("nd_wait_valid", 32'(got), 1);
    check("nd_wait_card", 32'(card), 1);
    check("nd_wait_left", 32'(cardsLeft), 52);

    // reset during ADDR
    do_reset();
    deal = 1'b1;
    tick();
    deal = 1'b0;
    check("rstmid_in_addr", 32'(dbg_state), 1);
    resetn = 1'b0;
    #1;
    check("rstmid_addr", 32'(Address), 63);
    check("rstmid_busy", 32'(busy), 0);
    @(posedge Clock);
    #1;
    resetn = 1'b1;
    expect_no_valid("rstmid_no_valid", 6);
    check("rstmid_left", 32'(cardsLeft), 52);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
